// File: rtl/complex_accumulator.sv
// Frame accumulator for complex products: sums N signed real/imag parts per frame
// and holds each finished frame in a valid/ready output register while the next one builds.
module complex_accumulator #(
  parameter int N     = 8,
  parameter int ACC_W = 20
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    Clear,
  input  logic                    InValid,
  output logic                    InReady,
  input  logic [33:0]             Product,
  output logic                    OutValid,
  input  logic                    OutReady,
  output logic signed [ACC_W-1:0] AccReal,
  output logic signed [ACC_W-1:0] AccImag,
  output logic                    Overflow
);

  localparam int CNT_W = $clog2(N);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  logic signed [ACC_W-1:0] acc_r, acc_i;
  logic signed [ACC_W-1:0] re_ext, im_ext, sum_r, sum_i;
  logic signed [16:0]      re, im;
  logic [CNT_W-1:0]        cnt;
  logic                    ovf;
  logic                    add_ovf;
  logic                    last;
  logic                    in_fire;
  logic                    out_fire;

  assign re     = Product[33:17];
  assign im     = Product[16:0];
  assign re_ext = ACC_W'(re);
  assign im_ext = ACC_W'(im);
  assign sum_r  = acc_r + re_ext;
  assign sum_i  = acc_i + im_ext;

  // Signed wrap: operands agree in sign but the sum does not.
  assign add_ovf =
    ((acc_r[ACC_W-1] == re_ext[ACC_W-1]) && (sum_r[ACC_W-1] != acc_r[ACC_W-1])) ||
    ((acc_i[ACC_W-1] == im_ext[ACC_W-1]) && (sum_i[ACC_W-1] != acc_i[ACC_W-1]));

  assign last     = (cnt == LAST);
  // Stall only when the completing sample would overwrite a result still held.
  assign InReady  = !Clear && !(last && OutValid && !OutReady);
  assign in_fire  = InValid && InReady;
  assign out_fire = OutValid && OutReady;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      acc_r <= '0;
      acc_i <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else if (Clear || (in_fire && last)) begin
      acc_r <= '0;
      acc_i <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else if (in_fire) begin
      acc_r <= sum_r;
      acc_i <= sum_i;
      cnt   <= cnt + 1'b1;
      ovf   <= ovf | add_ovf;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      OutValid <= 1'b0;
      AccReal  <= '0;
      AccImag  <= '0;
      Overflow <= 1'b0;
    end else if (in_fire && last) begin
      OutValid <= 1'b1;
      AccReal  <= sum_r;
      AccImag  <= sum_i;
      Overflow <= ovf | add_ovf;
    end else if (out_fire) begin
      OutValid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_complex_accumulator.sv
// Bench for complex_accumulator: directed steps with a reference model that scoreboards
// every frame, plus a small-width instance for the wrap/overflow boundary.
module tb_complex_accumulator;

  localparam int N = 8;
  localparam int W = 20;

  logic                Clk = 1'b0;
  logic                Reset = 1'b1;
  logic                Clear = 1'b0;
  logic                InValid = 1'b0;
  logic                InReady;
  logic [33:0]         Product = '0;
  logic                OutValid;
  logic                OutReady = 1'b1;
  logic signed [W-1:0] AccReal, AccImag;
  logic                Overflow;

  logic                b_InValid = 1'b0;
  logic                b_InReady;
  logic [33:0]         b_Product = '0;
  logic                b_OutValid;
  logic                b_OutReady = 1'b1;
  logic signed [16:0]  b_AccReal, b_AccImag;
  logic                b_Overflow;

  int errors = 0;
  int checks = 0;
  logic rand_ready = 1'b0;

  logic [2*W:0] exp_q[$];
  int   m_cnt = 0, m_re = 0, m_im = 0;
  logic m_ovf = 1'b0, m_ov = 1'b0;

  complex_accumulator #(.N(N), .ACC_W(W)) dut (
    .Clk(Clk), .Reset(Reset), .Clear(Clear), .InValid(InValid), .InReady(InReady),
    .Product(Product), .OutValid(OutValid), .OutReady(OutReady),
    .AccReal(AccReal), .AccImag(AccImag), .Overflow(Overflow)
  );

  complex_accumulator #(.N(2), .ACC_W(17)) dut_b (
    .Clk(Clk), .Reset(Reset), .Clear(1'b0), .InValid(b_InValid), .InReady(b_InReady),
    .Product(b_Product), .OutValid(b_OutValid), .OutReady(b_OutReady),
    .AccReal(b_AccReal), .AccImag(b_AccImag), .Overflow(b_Overflow)
  );

  // Clock/reset block
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  function automatic int wrap(input int v);
    logic [W-1:0] t;
    t = v[W-1:0];
    return int'($signed(t));
  endfunction

  function automatic logic oor(input int v);
    return (v > (2 ** (W - 1)) - 1) || (v < -(2 ** (W - 1)));
  endfunction

  // Reference model and scoreboard, evaluated on the falling edge for the next rising edge.
  always @(negedge Clk) begin
    logic exp_ready, ov_next, o;
    int   tr, ti;
    if (Reset) begin
      m_cnt = 0; m_re = 0; m_im = 0; m_ovf = 1'b0; m_ov = 1'b0;
      exp_q.delete();
    end else begin
      exp_ready = !Clear && !((m_cnt == N - 1) && m_ov && !OutReady);
      chk("in_ready", InReady, exp_ready);
      chk("out_valid", OutValid, m_ov);
      ov_next = m_ov;
      if (m_ov && exp_q.size() > 0) begin
        chk("frame_data", {Overflow, AccReal, AccImag}, exp_q[0]);
        if (OutReady) begin
          void'(exp_q.pop_front());
          ov_next = 1'b0;
        end
      end
      if (Clear) begin
        m_cnt = 0; m_re = 0; m_im = 0; m_ovf = 1'b0;
      end else if (InValid && exp_ready) begin
        tr = m_re + int'($signed(Product[33:17]));
        ti = m_im + int'($signed(Product[16:0]));
        o  = m_ovf | oor(tr) | oor(ti);
        if (m_cnt == N - 1) begin
          exp_q.push_back({o, W'(wrap(tr)), W'(wrap(ti))});
          ov_next = 1'b1;
          m_cnt = 0; m_re = 0; m_im = 0; m_ovf = 1'b0;
        end else begin
          m_cnt++; m_re = wrap(tr); m_im = wrap(ti); m_ovf = o;
        end
      end
      m_ov = ov_next;
    end
  end

  // Driver tasks: inputs change 2 time units after the rising edge.
  task automatic send(input logic signed [16:0] re, input logic signed [16:0] im);
    logic taken;
    int   n;
    InValid = 1'b1;
    Product = {re, im};
    n = 0;
    do begin
      @(negedge Clk);
      taken = InReady;
      @(posedge Clk);
      #2;
      n++;
      if (rand_ready) OutReady = 1'($urandom_range(0, 1));
    end while (!taken && n < 200);
    if (!taken) chk("send_timeout", {63'd0, taken}, 64'd1);
    InValid = 1'b0;
  endtask

  task automatic idle(input int n);
    InValid = 1'b0;
    repeat (n) begin
      @(posedge Clk);
      #2;
      if (rand_ready) OutReady = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic wait_out(input string tag, input int re, input int im);
    int n;
    n = 0;
    do begin
      @(negedge Clk);
      n++;
    end while (!OutValid && n < 50);
    chk({tag, "_valid"}, OutValid, 1);
    chk({tag, "_re"}, AccReal, re);
    chk({tag, "_im"}, AccImag, im);
  endtask

  initial begin
    repeat (2) @(posedge Clk);
    #2;
    Reset = 1'b0;

    // Reset mid-frame with a result pending
    OutReady = 1'b0;
    for (int i = 0; i < 8; i++) send(17'sd3, 17'sd4);
    for (int i = 0; i < 3; i++) send(17'sd7, 17'sd7);
    Reset = 1'b1;
    #1;
    chk("rst_out_valid", OutValid, 0);
    chk("rst_acc_real", AccReal, 0);
    chk("rst_acc_imag", AccImag, 0);
    chk("rst_overflow", Overflow, 0);
    chk("rst_in_ready", InReady, 1);
    @(posedge Clk);
    #2;
    Reset = 1'b0;
    OutReady = 1'b1;
    for (int i = 0; i < 8; i++) send(17'sd1, -17'sd1);
    wait_out("after_reset", 8, -8);
    idle(2);

    // Back-to-back streaming of two frames
    for (int i = 0; i < 16; i++) send(17'(i), 17'(-2 * i));
    wait_out("stream_f2", 92, -184);
    idle(2);

    // Backpressure: frame 1 held while frame 2 runs into the stall
    OutReady = 1'b0;
    for (int i = 0; i < 8; i++) send(17'(i + 1), 17'(i));
    fork
      for (int i = 0; i < 8; i++) send(17'(10 * i), 17'(-i));
      begin
        repeat (12) @(posedge Clk);
        #2;
        OutReady = 1'b1;
      end
    join
    wait_out("bp_f2", 280, -28);
    idle(2);

    // Clear discards a partial frame and leaves a pending result alone
    OutReady = 1'b0;
    for (int i = 0; i < 8; i++) send(17'sd2, 17'sd0);
    for (int i = 0; i < 3; i++) send(17'sd100, 17'sd0);
    Clear = 1'b1;
    InValid = 1'b1;
    Product = {17'sd100, 17'sd0};
    @(posedge Clk);
    #2;
    Clear = 1'b0;
    InValid = 1'b0;
    OutReady = 1'b1;
    for (int i = 0; i < 8; i++) send(17'sd5, 17'sd0);
    wait_out("clear", 40, 0);
    idle(2);

    // Extremes with random gaps and random OutReady
    rand_ready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      idle($urandom_range(0, 2));
      send(-17'sd65536, 17'sd65535);
    end
    rand_ready = 1'b0;
    OutReady = 1'b1;
    idle(4);
    chk("queue_drained", exp_q.size(), 0);

    // Wrap at ACC_W = 17, N = 2
    b_InValid = 1'b1;
    b_Product = {17'sd40000, 17'sd0};
    @(posedge Clk);
    #2;
    @(posedge Clk);
    #2;
    b_InValid = 1'b0;
    @(negedge Clk);
    chk("ovf_valid", b_OutValid, 1);
    chk("ovf_flag", b_Overflow, 1);
    chk("ovf_re", b_AccReal, -51072);
    chk("ovf_im", b_AccImag, 0);
    @(posedge Clk);
    #2;
    b_InValid = 1'b1;
    b_Product = {17'sd3, -17'sd2};
    @(posedge Clk);
    #2;
    @(posedge Clk);
    #2;
    b_InValid = 1'b0;
    @(negedge Clk);
    chk("small_valid", b_OutValid, 1);
    chk("small_flag", b_Overflow, 0);
    chk("small_re", b_AccReal, 6);
    chk("small_im", b_AccImag, -4);
    chk("small_in_ready", b_InReady, 1);
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/complex_accumulator.md
# complex_accumulator

Downstream consumer of the complex multiplier's registered 34-bit product word. It accumulates frames of `N` complex products into signed real/imag sums and presents each finished frame on a valid/ready output register. The output stage is double-buffered, so accumulation of the next frame overlaps draining of the previous one. Typical use is complex dot products and correlator taps.

## Interface
- `N`, default 8: products per frame; must be ≥ 2.
- `ACC_W`, default 20: accumulator width per part, signed; must be ≥ 17.
- `Clk`  input  1: rising-edge clock.
- `Reset`  input  1: asynchronous, active-high; clears all state.
- `Clear`  input  1: synchronous; discards the partial frame.
- `InValid`  input  1: `Product` is valid this cycle.
- `InReady`  output  1: block accepts `Product` this cycle (combinational).
- `Product`  input  34: `[33:17]` real, 17-bit signed; `[16:0]` imag, 17-bit signed.
- `OutValid`  output  1: a frame result is held on the outputs.
- `OutReady`  input  1: consumer takes the result this cycle.
- `AccReal`  output  ACC_W: frame sum of the real parts, signed.
- `AccImag`  output  ACC_W: frame sum of the imag parts, signed.
- `Overflow`  output  1: the frame's sum wrapped in either part.

## Operation
- An input transfer happens when `InValid && InReady`. An output transfer happens when `OutValid && OutReady`.
- Internal state:
  - `accR`, `accI`: ACC_W bits each.
  - `cnt`: counts 0..N-1.
  - `ovf`: sticky overflow flag for the frame in progress.
  - Output registers.
- Arithmetic:
  - Each 17-bit part is sign-extended to ACC_W and added two's-complement, wrapping modulo 2^ACC_W.
  - A part overflows when both operands have the same sign and the sum's sign differs.
- Accepted sample with `cnt < N-1`:
  - `accR += re`, `accI += im`.
  - `cnt++`.
  - `ovf |= overflow of this add`.
- Accepted sample with `cnt == N-1` (frame completes):
  - `AccReal ← accR+re` and `AccImag ← accI+im`.
  - `Overflow ← ovf | overflow of this add`.
  - `OutValid ← 1`.
  - `accR`, `accI`, `cnt` and `ovf` all go to 0.
- Output transfer with no frame completing in the same cycle: `OutValid ← 0`. The data outputs keep their last values.
- Output transfer and frame completion in the same cycle: the new result loads and `OutValid` stays 1.
- Backpressure: `InReady = !Clear && !(cnt == N-1 && OutValid && !OutReady)`. The block stalls only when the completing sample has nowhere to go.
- `Clear`:
  - Zeroes `accR`, `accI`, `cnt` and `ovf`.
  - Any sample presented that cycle is not accepted, because `InReady` is 0.
  - Does not touch `OutValid` or the output registers. An output transfer in the same cycle still completes normally.
- `Reset` is asserted asynchronously at any point, including mid-frame or with output pending. The outputs go immediately to:
  - `OutValid` = 0
  - `AccReal` = 0
  - `AccImag` = 0
  - `Overflow` = 0
  - internal accumulators and `cnt` = 0

  `InReady` then reads 1 while `Clear` is low.
- `Product` is ignored when `InValid` is 0. Gaps between samples are allowed anywhere in a frame.

## Timing
- Latency: `OutValid` rises on the clock edge that accepts the N-th sample, so results are visible in the cycle after that sample.
- Throughput: one sample per cycle with no bubbles while `OutReady` is high. Frame k+1 accumulates while frame k is held.
- `InReady` depends combinationally on `Clear`, `OutReady`, `cnt` and `OutValid`. It has no path from `InValid` or `Product`.
- `OutValid`, `AccReal`, `AccImag` and `Overflow` are registered, with no combinational input paths.
- While `OutValid && !OutReady`, the outputs are stable. Stalled input is held off; no sample is lost or double-counted.

## Test plan
- **Reset values:** Apply `Reset` mid-frame (cnt = 3) with `OutValid` = 1. Immediately after, `OutValid` = 0, `AccReal` = 0, `AccImag` = 0, `Overflow` = 0. Then 8 samples of {re = 1, im = −1} give `AccReal` = 8, `AccImag` = −8.
- **Streaming:** N = 8, `OutReady` held 1. Feed 16 back-to-back samples, re = i and im = −2i for i = 0..15. Required: `OutValid` pulses one cycle after samples 7 and 15. Results are (28, −56) and (92, −184). `InReady` never drops.
- **Backpressure:** Hold `OutReady` = 0 after frame 1 completes. Present frame 2 continuously. Required: `InReady` = 0 at cnt = 7 and frame 1 stays stable. When `OutReady` rises, frame 2 completes in that same cycle and `OutValid` stays 1. The frame 2 sum is correct, with no lost or duplicated sample.
- **Clear:** Accept 3 samples of re = 100, assert `Clear` with `InValid` high for one cycle, then feed 8 samples of re = 5. Required: the result is `AccReal` = 40. The cleared sample is not counted. A pending output is undisturbed.
- **Overflow:** ACC_W = 17, N = 2. Feed re = 40000 twice; 40000 is 17-bit representable and 80000 is not. Required: `Overflow` = 1 and `AccReal` = 80000 − 131072 = −51072. The next frame of small values gives `Overflow` = 0.
- **Extremes and gaps:** Samples of re = −65536, im = 65535 with random `InValid` gaps and random `OutReady`. Compare against a reference model; sums must match at every output transfer.
